// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants for the FIFO stream reader: skid depth, default batch length
// and the occupancy type used by the skid buffer.
package fifo_stream_reader_pkg;

  localparam int SKID_DEPTH        = 2;
  localparam int FRAME_LEN_DEFAULT = 2048;

  // Occupancy counts 0..SKID_DEPTH, so it needs one bit more than the pointers.
  typedef logic [1:0] occ_t;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry skid buffer that absorbs words arriving one cycle after the FIFO read
// strobe. The head entry is presented directly as the stream output.
module stream_skid_buf
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output occ_t             occ
);

  logic [WIDTH-1:0] mem [SKID_DEPTH];
  logic             head;
  logic             tail;
  logic             do_pop;

  assign do_pop = rd_en & (occ != '0);
  assign valid  = (occ != '0);
  assign data   = mem[head];

  // A capture and a pop in the same cycle both take effect; occupancy nets out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
      head <= 1'b0;
      tail <= 1'b0;
      occ  <= '0;
    end else begin
      if (wr_en) begin
        mem[tail] <= wr_data;
        tail      <= ~tail;
      end
      if (do_pop) head <= ~head;
      occ <= occ + occ_t'(wr_en) - occ_t'(do_pop);
    end
  end

  // The read-issue rule upstream must never let the buffer overflow.
  a_occ_bound : assert property (@(posedge clk) disable iff (!rst_n)
    (occ <= occ_t'(SKID_DEPTH)) && !(wr_en && !do_pop && (occ == occ_t'(SKID_DEPTH))));

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for the FIFO: issues reads, hides the one-cycle read latency
// with a skid buffer and marks batch boundaries on the valid/ready stream.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int FRAME_LEN = FRAME_LEN_DEFAULT,
  parameter int CNT_W     = $clog2(FRAME_LEN) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_read,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic [CNT_W-1:0] frame_cnt
);

  if (FRAME_LEN < 1) begin : g_frame_len_check
    $error("fifo_stream_reader: FRAME_LEN must be at least 1");
  end

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  logic             in_flight;
  logic             pop;
  occ_t             occ;
  logic [2:0]       pending;
  logic [CNT_W-1:0] word_cnt;

  assign pop     = m_valid & m_ready;
  assign pending = {1'b0, occ} + {2'b00, in_flight};

  // A read may go out when a slot is guaranteed free, counting the word already
  // in flight; a same-cycle pop frees one slot.
  assign fifo_read = rst_n & enable & ~fifo_empty
                   & ((pending < 3'(SKID_DEPTH)) | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_flight <= 1'b0;
    else        in_flight <= fifo_read;
  end

  stream_skid_buf #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (in_flight),
    .wr_data (fifo_data),
    .rd_en   (pop),
    .valid   (m_valid),
    .data    (m_data),
    .occ     (occ)
  );

  assign m_last = m_valid & (word_cnt == LAST_IDX);

  // Words are counted only when accepted downstream; the last one closes a batch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt  <= '0;
      frame_cnt <= '0;
    end else if (pop) begin
      if (m_last) begin
        word_cnt  <= '0;
        frame_cnt <= frame_cnt + 1'b1;
      end else begin
        word_cnt <= word_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench: a behavioural FIFO feeds the reader, and an in-order word
// list plus a pop count predict every accepted word, m_last and frame_cnt.
module tb_fifo_stream_reader;

  localparam int WIDTH = 32;
  localparam int FL    = 4;
  localparam int CNT_W = $clog2(FL) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_read;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic [CNT_W-1:0] frame_cnt;

  logic [WIDTH-1:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int exp_idx = 0;
  int pop_count = 0;
  int n_checks = 0;
  int n_errors = 0;
  int rd_start;

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .WIDTH     (WIDTH),
    .FRAME_LEN (FL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_read  (fifo_read),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .frame_cnt  (frame_cnt)
  );

  // FIFO model: combinational empty flag, registered one-cycle read data, no reset.
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_read && (rd_ptr < wr_ptr)) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [WIDTH-1:0] word);
    mem[wr_ptr] = word;
    wr_ptr++;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (exp_idx == wr_ptr && !m_valid) break;
    end
    check_output("drain", 64'(exp_idx), 64'(wr_ptr));
  endtask

  // Reference: accepted words appear in FIFO order; anything read but not
  // accepted before a reset is lost, so the next expected word is the FIFO head.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_idx   = rd_ptr;
      pop_count = 0;
    end else begin
      check_output("read_when_empty", 64'(fifo_read & fifo_empty), 64'd0);
      check_output("frame_cnt", 64'(frame_cnt), 64'((pop_count / FL) % (1 << CNT_W)));
      if (m_valid) begin
        if (exp_idx >= wr_ptr) begin
          check_output("spurious_word", 64'(m_data), 64'hdead_0000_0000_0000);
        end else begin
          check_output("m_data", 64'(m_data), 64'(mem[exp_idx]));
          check_output("m_last", 64'(m_last), 64'((pop_count % FL) == FL - 1));
          if (m_ready) begin
            exp_idx++;
            pop_count++;
          end
        end
      end else begin
        check_output("m_last_idle", 64'(m_last), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    enable  = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) apply_stimulus(WIDTH'(32'h10 + i));
    #12;
    check_output("rst_fifo_read", 64'(fifo_read), 64'd0);
    check_output("rst_m_valid", 64'(m_valid), 64'd0);
    check_output("rst_m_data", 64'(m_data), 64'd0);
    check_output("rst_m_last", 64'(m_last), 64'd0);
    check_output("rst_frame_cnt", 64'(frame_cnt), 64'd0);

    $display("[TB] step 1: preloaded burst");
    @(posedge clk); #1;
    rst_n  = 1'b1;
    enable = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check_output("t1_fifo_read", 64'(fifo_read), 64'(c < 4));
      check_output("t1_m_valid", 64'(m_valid), 64'(c >= 2 && c < 6));
      if (c >= 2 && c < 6) check_output("t1_m_data", 64'(m_data), 64'(32'h10 + c - 2));
    end
    wait_drain();

    $display("[TB] step 2: stalled sink");
    m_ready  = 1'b0;
    rd_start = rd_ptr;
    for (int i = 0; i < 8; i++) apply_stimulus($urandom);
    repeat (6) @(posedge clk);
    #1;
    check_output("t2_reads", 64'(rd_ptr - rd_start), 64'd2);
    check_output("t2_m_valid", 64'(m_valid), 64'd1);
    check_output("t2_m_data", 64'(m_data), 64'(mem[rd_start]));
    m_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      check_output("t2_no_gap", 64'(m_valid), 64'(c < 8));
    end
    wait_drain();

    $display("[TB] step 3: random backpressure");
    for (int i = 0; i < 100; i++) apply_stimulus($urandom);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      m_ready = 1'($urandom_range(0, 1));
      if (exp_idx == wr_ptr) break;
    end
    m_ready = 1'b1;
    wait_drain();

    $display("[TB] step 4: batch boundaries");
    for (int i = 0; i < 10; i++) apply_stimulus($urandom);
    wait_drain();
    check_output("t4_word_cnt", 64'(dut.word_cnt), 64'(pop_count % FL));
    check_output("t4_frame_cnt", 64'(frame_cnt), 64'((pop_count / FL) % (1 << CNT_W)));

    $display("[TB] step 5: enable dropped after a read");
    @(posedge clk); #1;
    rd_start = rd_ptr;
    for (int i = 0; i < 3; i++) apply_stimulus($urandom);
    @(posedge clk); #1;
    enable = 1'b0;
    @(negedge clk);
    check_output("t5_no_read", 64'(fifo_read), 64'd0);
    @(posedge clk); #1;
    enable = 1'b1;
    @(negedge clk);
    check_output("t5_inflight_valid", 64'(m_valid), 64'd1);
    check_output("t5_inflight_data", 64'(m_data), 64'(mem[rd_start]));
    check_output("t5_read_count", 64'(rd_ptr - rd_start), 64'd1);
    wait_drain();

    $display("[TB] step 6: reset with a full buffer");
    m_ready  = 1'b0;
    rd_start = rd_ptr;
    for (int i = 0; i < 5; i++) apply_stimulus($urandom);
    repeat (5) @(posedge clk);
    #1;
    check_output("t6_full_valid", 64'(m_valid), 64'd1);
    check_output("t6_full_occ", 64'(dut.u_skid.occ), 64'd2);
    rst_n = 1'b0;
    #1;
    check_output("t6_rst_m_valid", 64'(m_valid), 64'd0);
    check_output("t6_rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check_output("t6_rst_fifo_read", 64'(fifo_read), 64'd0);
    @(posedge clk); #1;
    rst_n   = 1'b1;
    m_ready = 1'b1;
    wait_drain();
    check_output("t6_resume_reads", 64'(rd_ptr - rd_start), 64'd5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
